// File: rtl/lsu_uart_sequencer.sv
// rtl/lsu_uart_sequencer.sv - MEM-stage stall sequencer for LSU accesses to the UART page
// Optional access timeout is built when LSU_UART_TIMEOUT_EN is defined.
module lsu_uart_sequencer #(
    parameter int UART_PAGE      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        pipe_en,
    output logic        mem_sel,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [3:0] PAGE     = 4'(UART_PAGE);

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_ack_q, rx_ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic is_ld, is_st, is_uart, expired;

    always_comb begin
        is_ld   = (opcode == OP_LOAD);
        is_st   = (opcode == OP_STORE);
        is_uart = (is_ld | is_st) & (address[11:8] == PAGE);
        mem_sel = (is_ld | is_st) & ~is_uart;
    end

    logic unused_bits;
    assign unused_bits = ^{wdata[31:8], address[31:12], address[7:0]};

`ifdef LSU_UART_TIMEOUT_EN
    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign expired = (cnt_q == CNT_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rx_ack_d   = 1'b0;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
`ifdef LSU_UART_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (is_uart && is_st) begin
                    tx_data_d  = wdata[7:0];
                    tx_valid_d = 1'b1;
                    state_d    = WR_REQ;
`ifdef LSU_UART_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end else if (is_uart && is_ld) begin
                    state_d = RD_WAIT;
`ifdef LSU_UART_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            // A handshake on the expiry cycle takes priority over the timeout.
            WR_REQ: begin
                if (tx_valid_q && uart_tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = DONE;
                end else if (expired) begin
                    tx_valid_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = DONE;
                end else begin
`ifdef LSU_UART_TIMEOUT_EN
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            RD_WAIT: begin
                if (uart_rx_valid) begin
                    rdata_d  = {24'b0, uart_rx_data};
                    rx_ack_d = 1'b1;
                    state_d  = DONE;
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
`ifdef LSU_UART_TIMEOUT_EN
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rx_ack_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
`ifdef LSU_UART_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_ack_q   <= rx_ack_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
`ifdef LSU_UART_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // DONE releases the pipeline for one cycle without re-decoding the held instruction.
    assign pipe_en = ~(((state_q == IDLE) && is_uart) || (state_q == WR_REQ) || (state_q == RD_WAIT));

    assign uart_tx_valid = tx_valid_q;
    assign uart_tx_data  = tx_data_q;
    assign uart_rx_ack   = rx_ack_q;
    assign rdata         = rdata_q;
    assign err           = err_q;

endmodule

// File: tb/tb_lsu_uart_sequencer.sv
// tb/tb_lsu_uart_sequencer.sv - scoreboard bench for lsu_uart_sequencer
module tb_lsu_uart_sequencer;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_NOP = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        pipe_en;
    logic        mem_sel;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ack;
    logic [31:0] rdata;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  tx_exp_q[$];
    logic [31:0] rx_exp_q[$];
    logic [31:0] last_rdata = 32'h0;
    logic        err_allowed = 1'b0;
    logic        ack_prev = 1'b0;
    logic [7:0]  mon_tx;
    logic [31:0] mon_rx;

    lsu_uart_sequencer #(.UART_PAGE(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .address(address), .wdata(wdata),
        .pipe_en(pipe_en), .mem_sel(mem_sel),
        .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ack(uart_rx_ack),
        .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (uart_tx_valid && uart_tx_ready) begin
            compared++;
            if (tx_exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL tx_unexpected: byte %h sent, no byte expected", uart_tx_data);
            end else begin
                mon_tx = tx_exp_q.pop_front();
                if (uart_tx_data !== mon_tx) begin
                    mismatched++;
                    $display("FAIL tx_data: got %h want %h", uart_tx_data, mon_tx);
                end
            end
        end
        if (uart_rx_ack) begin
            compared++;
            if (rx_exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL rx_unexpected_ack: rdata %h, no load pending", rdata);
            end else begin
                mon_rx = rx_exp_q.pop_front();
                if (rdata !== mon_rx) begin
                    mismatched++;
                    $display("FAIL rx_rdata: got %h want %h", rdata, mon_rx);
                end
            end
            compared++;
            if (ack_prev !== 1'b0) begin
                mismatched++;
                $display("FAIL rx_ack_pulse: ack high %0d cycles in a row, want 1", 2);
            end
        end
        if (err !== 1'b0 && !err_allowed) begin
            compared++;
            mismatched++;
            $display("FAIL err_spurious: got %b want 0", err);
        end
        ack_prev = uart_rx_ack;
    end

    task automatic next();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = OP_NOP; address = 32'h0; wdata = 32'h0;
        uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h0;
        next(); #1;
        compared++;
        if ({uart_tx_valid, uart_rx_ack, err, pipe_en, mem_sel} !== 5'b00010) begin
            mismatched++;
            $display("FAIL reset_ctrl: got tx_valid/ack/err/pipe_en/mem_sel=%b want 00010",
                     {uart_tx_valid, uart_rx_ack, err, pipe_en, mem_sel});
        end
        compared++;
        if (rdata !== 32'h0 || uart_tx_data !== 8'h0) begin
            mismatched++;
            $display("FAIL reset_data: got rdata=%h tx_data=%h want 0/0", rdata, uart_tx_data);
        end
        next(); rst = 1'b0;
    endtask

    task automatic test_store_basic();
        next(); opcode = OP_ST; address = 32'h400; wdata = 32'h1234_56A5; uart_tx_ready = 1'b1;
        tx_exp_q.push_back(8'hA5);
        #1; compared++;
        if (pipe_en !== 1'b0 || uart_tx_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL st_idle: got pipe_en=%b tx_valid=%b want 0/0", pipe_en, uart_tx_valid);
        end
        next(); #1; compared++;
        if (pipe_en !== 1'b0 || uart_tx_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL st_wr_req: got pipe_en=%b tx_valid=%b want 0/1", pipe_en, uart_tx_valid);
        end
        next(); opcode = OP_NOP; uart_tx_ready = 1'b0;
        #1; compared++;
        if (pipe_en !== 1'b1 || uart_tx_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL st_done: got pipe_en=%b tx_valid=%b want 1/0", pipe_en, uart_tx_valid);
        end
        next(); #1; compared++;
        if (pipe_en !== 1'b1 || tx_exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL st_idle_after: got pipe_en=%b pending=%0d want 1/0", pipe_en, tx_exp_q.size());
        end
    endtask

    task automatic test_load_basic();
        int stalls = 0;
        next(); opcode = OP_LD; address = 32'h404; uart_rx_valid = 1'b0;
        #1; if (!pipe_en) stalls++;
        for (int i = 0; i < 5; i++) begin
            next();
            if (i == 4) begin
                uart_rx_valid = 1'b1; uart_rx_data = 8'h3C; rx_exp_q.push_back(32'h0000_003C);
            end
            #1; if (!pipe_en) stalls++;
        end
        compared++;
        if (stalls != 6) begin
            mismatched++;
            $display("FAIL ld_stalls: got %0d want 6", stalls);
        end
        next(); opcode = OP_NOP; uart_rx_valid = 1'b0;
        #1; compared++;
        if (pipe_en !== 1'b1 || uart_rx_ack !== 1'b1 || rdata !== 32'h3C) begin
            mismatched++;
            $display("FAIL ld_done: got pipe_en=%b ack=%b rdata=%h want 1/1/0000003c", pipe_en, uart_rx_ack, rdata);
        end
        last_rdata = 32'h3C;
        next(); #1; compared++;
        if (uart_rx_ack !== 1'b0 || rdata !== 32'h3C || rx_exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL ld_after: got ack=%b rdata=%h pending=%0d want 0/3c/0", uart_rx_ack, rdata, rx_exp_q.size());
        end
    endtask

    task automatic test_mem_passthrough();
        logic [6:0]  ops[3]  = '{OP_LD, OP_ST, OP_NOP};
        logic [31:0] adrs[3] = '{32'h200, 32'h100, 32'h400};
        logic        msel[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            next(); opcode = ops[i]; address = adrs[i]; wdata = 32'hFFFF_FF11;
            uart_rx_valid = 1'b1; uart_rx_data = 8'hEE; uart_tx_ready = 1'b1;
            for (int c = 0; c < 2; c++) begin
                if (c == 1) next();
                #1; compared++;
                if (pipe_en !== 1'b1 || mem_sel !== msel[i] || uart_tx_valid !== 1'b0 ||
                    uart_rx_ack !== 1'b0 || rdata !== last_rdata) begin
                    mismatched++;
                    $display("FAIL pass_%0d: got pipe_en=%b mem_sel=%b tx_valid=%b ack=%b rdata=%h want 1/%b/0/0/%h",
                             i, pipe_en, mem_sel, uart_tx_valid, uart_rx_ack, rdata, msel[i], last_rdata);
                end
            end
        end
        next(); opcode = OP_NOP; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 10; n++) begin
            int  delay = $urandom_range(0, 5);
            bit  is_st = $urandom_range(0, 1) == 1;
            int  stalls = 0;
            int  c = 0;
            bit  done = 0;
            logic [7:0] b = 8'($urandom);
            next();
            opcode = is_st ? OP_ST : OP_LD;
            address = {20'h0, 4'h4, 8'($urandom)};
            wdata = {24'($urandom), b};
            uart_rx_data = b;
            if (is_st) tx_exp_q.push_back(b); else rx_exp_q.push_back({24'h0, b});
            while (c < 40 && !done) begin
                if (is_st) uart_tx_ready = (c >= 1) && (c - 1 >= delay);
                else       uart_rx_valid = (c >= 1) && (c - 1 >= delay);
                #1;
                if (pipe_en) done = 1; else stalls++;
                if (!done) begin next(); c++; end
            end
            compared++;
            if (!done || stalls != delay + 2) begin
                mismatched++;
                $display("FAIL b2b_%0d: got stalls=%0d done=%0d want stalls=%0d done=1", n, stalls, done, delay + 2);
            end
            if (!is_st) last_rdata = {24'h0, b};
            opcode = OP_NOP; uart_tx_ready = 1'b0; uart_rx_valid = 1'b0;
        end
        next(); #1; compared++;
        if (tx_exp_q.size() != 0 || rx_exp_q.size() != 0 || rdata !== last_rdata) begin
            mismatched++;
            $display("FAIL b2b_drain: got tx=%0d rx=%0d rdata=%h want 0/0/%h",
                     tx_exp_q.size(), rx_exp_q.size(), rdata, last_rdata);
        end
    endtask

`ifdef LSU_UART_TIMEOUT_EN
    task automatic test_timeout();
        int stalls = 0;
        next(); opcode = OP_LD; address = 32'h400; uart_rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            next(); #1; if (!pipe_en) stalls++;
        end
        compared++;
        if (stalls != 8) begin
            mismatched++;
            $display("FAIL to_ld_stalls: got %0d want 8", stalls);
        end
        err_allowed = 1'b1;
        next(); opcode = OP_NOP;
        #1; compared++;
        if (pipe_en !== 1'b1 || err !== 1'b1 || rdata !== 32'h0 || uart_rx_ack !== 1'b0) begin
            mismatched++;
            $display("FAIL to_ld_done: got pipe_en=%b err=%b rdata=%h ack=%b want 1/1/0/0", pipe_en, err, rdata, uart_rx_ack);
        end
        last_rdata = 32'h0;
        next(); #1; err_allowed = 1'b0; compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL to_err_pulse: got %b want 0", err);
        end
        next(); opcode = OP_ST; address = 32'h4AA; wdata = 32'h77; uart_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) next();
        err_allowed = 1'b1; opcode = OP_NOP;
        #1; compared++;
        if (err !== 1'b1 || uart_tx_valid !== 1'b0 || pipe_en !== 1'b1) begin
            mismatched++;
            $display("FAIL to_st_done: got err=%b tx_valid=%b pipe_en=%b want 1/0/1", err, uart_tx_valid, pipe_en);
        end
        next(); #1; err_allowed = 1'b0;
    endtask

    task automatic test_timeout_race();
        next(); opcode = OP_LD; address = 32'h400; uart_rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            next();
            if (i == 7) begin
                uart_rx_valid = 1'b1; uart_rx_data = 8'h5A; rx_exp_q.push_back(32'h5A);
            end
        end
        next(); opcode = OP_NOP; uart_rx_valid = 1'b0;
        #1; compared++;
        if (err !== 1'b0 || uart_rx_ack !== 1'b1 || rdata !== 32'h5A || pipe_en !== 1'b1) begin
            mismatched++;
            $display("FAIL race_done: got err=%b ack=%b rdata=%h pipe_en=%b want 0/1/5a/1", err, uart_rx_ack, rdata, pipe_en);
        end
        last_rdata = 32'h5A;
        next();
    endtask
`else
    task automatic test_no_timeout();
        int stalls = 0;
        next(); opcode = OP_LD; address = 32'h4F0; uart_rx_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            next(); #1; if (!pipe_en && !err) stalls++;
        end
        compared++;
        if (stalls != 30) begin
            mismatched++;
            $display("FAIL wait_forever: got %0d stalled cycles want 30", stalls);
        end
        uart_rx_valid = 1'b1; uart_rx_data = 8'h77; rx_exp_q.push_back(32'h77);
        next(); opcode = OP_NOP; uart_rx_valid = 1'b0;
        #1; compared++;
        if (pipe_en !== 1'b1 || err !== 1'b0 || rdata !== 32'h77) begin
            mismatched++;
            $display("FAIL wait_done: got pipe_en=%b err=%b rdata=%h want 1/0/77", pipe_en, err, rdata);
        end
        last_rdata = 32'h77;
        next();
    endtask
`endif

    task automatic test_reset_mid();
        next(); opcode = OP_ST; address = 32'h400; wdata = 32'h99; uart_tx_ready = 1'b0;
        next(); next(); next();
        rst = 1'b1;
        #1; compared++;
        if (uart_tx_valid !== 1'b0 || uart_rx_ack !== 1'b0 || err !== 1'b0 ||
            rdata !== 32'h0 || uart_tx_data !== 8'h0) begin
            mismatched++;
            $display("FAIL rst_mid: got tx_valid=%b ack=%b err=%b rdata=%h tx_data=%h want 0/0/0/0/0",
                     uart_tx_valid, uart_rx_ack, err, rdata, uart_tx_data);
        end
        next(); opcode = OP_NOP; rst = 1'b0; uart_tx_ready = 1'b1;
        next(); #1; compared++;
        if (pipe_en !== 1'b1 || uart_tx_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_idle: got pipe_en=%b tx_valid=%b want 1/0", pipe_en, uart_tx_valid);
        end
        uart_tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_basic();
        test_load_basic();
        test_mem_passthrough();
        test_back_to_back();
`ifdef LSU_UART_TIMEOUT_EN
        test_timeout();
        test_timeout_race();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        next(); #1; compared++;
        if (tx_exp_q.size() != 0 || rx_exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL final_drain: got tx=%0d rx=%0d pending want 0/0", tx_exp_q.size(), rx_exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
